// File: rtl/gpioemu_mulpop.sv
// gpioemu_mulpop: bus-mapped shift-add multiplier with popcount and op counter; define GPIOEMU_MULPOP_HIWORD_EN for the R+0x28 high-word register
module gpioemu_mulpop #(
    parameter int          OP_W      = 24,
    parameter int          RES_W     = 32,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0380
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_in_s_insp
);
    localparam int AW = 2 * OP_W;
    localparam int IW = OP_W > 1 ? $clog2(OP_W) : 1;
    localparam logic [15:0] A_A1 = BASE_ADDR;
    localparam logic [15:0] A_A2 = BASE_ADDR + 16'h08;
    localparam logic [15:0] A_W  = BASE_ADDR + 16'h10;
    localparam logic [15:0] A_L  = BASE_ADDR + 16'h18;
    localparam logic [15:0] A_ST = BASE_ADDR + 16'h20;
    typedef enum logic [1:0] {IDLE, MULT, COUNT, DONE} state_t;
    state_t state, nxt;
    logic swr_q, srd_q, lat_q, wr_e, rd_e, lat_e, start, ready, valid;
    logic [OP_W-1:0] a1, a2, a2s;
    logic [AW-1:0] a1s, acc;
    logic [IW-1:0] idx;
    logic [RES_W-1:0] w_q;
    logic [5:0] l_q, pop;
    logic [CNT_W-1:0] cnt;
    logic [31:0] gpio_in_s, rd_val;
`ifdef GPIOEMU_MULPOP_HIWORD_EN
    localparam logic [15:0] A_HI = BASE_ADDR + 16'h28;
    logic [31:0] hi_q;
`endif
    logic unused;
    assign unused = &{1'b0, sdata_in};
    assign wr_e = swr & ~swr_q;
    assign rd_e = srd & ~srd_q;
    assign lat_e = gpio_latch & ~lat_q;
    assign start = wr_e && saddress == A_ST;
    assign gpio_out = 32'(cnt);
    assign gpio_in_s_insp = gpio_in_s;
    // strobe history for rising-edge detection
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) {swr_q, srd_q, lat_q} <= '0;
        else {swr_q, srd_q, lat_q} <= {swr, srd, gpio_latch};
    // FSM state register
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) state <= IDLE;
        else state <= nxt;
    // FSM next state: one MULT cycle per operand bit, then COUNT and DONE
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? MULT : IDLE;
            MULT:    nxt = idx == IW'(OP_W - 1) ? COUNT : MULT;
            COUNT:   nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    // popcount of the published result bits
    always_comb begin
        pop = '0;
        for (int k = 0; k < RES_W; k++) pop = pop + 6'(acc[k]);
    end
    // operand registers, shift-add datapath and published results
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            {a1, a2, a2s, a1s, acc, idx, w_q, l_q, cnt} <= '0;
            {ready, valid} <= 2'b11;
`ifdef GPIOEMU_MULPOP_HIWORD_EN
            hi_q <= '0;
`endif
        end else begin
            if (wr_e && saddress == A_A1) a1 <= sdata_in[OP_W-1:0];
            if (wr_e && saddress == A_A2) a2 <= sdata_in[OP_W-1:0];
            if (state == IDLE && start) begin
                a1s <= AW'(a1);
                a2s <= a2;
                acc <= '0;
                idx <= '0;
                ready <= 1'b0;
            end
            if (state == MULT) begin
                acc <= acc + (a2s[0] ? a1s : '0);
                a1s <= a1s << 1;
                a2s <= a2s >> 1;
                idx <= idx + 1'b1;
            end
            if (state == COUNT) begin
                w_q <= acc[RES_W-1:0];
                l_q <= pop;
                valid <= (acc >> RES_W) == '0;
`ifdef GPIOEMU_MULPOP_HIWORD_EN
                hi_q <= 32'(acc >> RES_W);
`endif
            end
            if (state == DONE) begin
                ready <= 1'b1;
                cnt <= cnt + 1'b1;
            end
        end
    // read data selection; unmapped addresses read zero
    always_comb begin
        rd_val = '0;
        if (saddress == A_W) rd_val = 32'(w_q);
        if (saddress == A_L) rd_val = 32'(l_q);
        if (saddress == A_ST) rd_val = {30'b0, ready, valid};
`ifdef GPIOEMU_MULPOP_HIWORD_EN
        if (saddress == A_HI) rd_val = hi_q;
`endif
    end
    // registered read port and GPIO input latch
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) {sdata_out, gpio_in_s} <= '0;
        else begin
            if (rd_e) sdata_out <= rd_val;
            if (lat_e) gpio_in_s <= gpio_in;
        end
endmodule

// File: tb/tb_gpioemu_mulpop.sv
// tb_gpioemu_mulpop: randomized self-checking bench with a product-level reference model
module tb_gpioemu_mulpop;
    localparam int OP_W = 24, RES_W = 32, CNT_W = 4;
    localparam logic [15:0] R = 16'h0380;
    logic clk = 0, n_reset = 0, srd = 0, swr = 0, gpio_latch = 0;
    logic [15:0] saddress = 0;
    logic [31:0] sdata_in = 0, gpio_in = 0, sdata_out, gpio_out, gpio_in_s_insp;
    int total = 0, bad = 0;
    logic [31:0] m_w = 0, m_l = 0, m_hi = 0, e_hi, e_mid, e_st;
    logic m_valid = 1;
    int m_cnt = 0;
    logic [31:0] o_mid, o_st, o_w, o_l, o_hi;

    always #5 clk = ~clk;

    gpioemu_mulpop #(.OP_W(OP_W), .RES_W(RES_W), .CNT_W(CNT_W), .BASE_ADDR(R)) dut (
        .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
        .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
        .gpio_latch(gpio_latch), .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp)
    );

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        saddress = a;
        sdata_in = d;
        swr = 1;
        @(negedge clk);
        swr = 0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        saddress = a;
        srd = 1;
        @(negedge clk);
        d = sdata_out;
        srd = 0;
    endtask

    // reference: result fields derived from the full integer product
    task automatic model_op(input logic [23:0] a1, input logic [23:0] a2);
        logic [63:0] p;
        p = 64'(a1) * 64'(a2);
        m_w = p[31:0];
        m_hi = p[63:32];
        m_valid = m_hi == 0;
        m_l = $countones(m_w);
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
`ifdef GPIOEMU_MULPOP_HIWORD_EN
        e_hi = m_hi;
`else
        e_hi = 0;
`endif
        e_st = {30'b0, 1'b1, m_valid};
    endtask

    task automatic read_results();
        rd(R + 16'h20, o_st);
        rd(R + 16'h10, o_w);
        rd(R + 16'h18, o_l);
        rd(R + 16'h28, o_hi);
    endtask

    task automatic run_op(input logic [23:0] a1, input logic [23:0] a2);
        wr(R, 32'(a1) | 32'($urandom_range(255)) << 24);
        wr(R + 16'h08, 32'(a2));
        e_mid = {30'b0, 1'b0, m_valid};
        wr(R + 16'h20, $urandom);
        rd(R + 16'h20, o_mid);
        repeat (OP_W) @(negedge clk);
        model_op(a1, a2);
        read_results();
    endtask

    task automatic test_reset();
        n_reset = 0;
        repeat (3) @(negedge clk);
        n_reset = 1;
        total++; if (gpio_out !== 0) begin bad++; $display("FAIL reset_gpio_out: got %h want 0", gpio_out); end
        total++; if (gpio_in_s_insp !== 0) begin bad++; $display("FAIL reset_insp: got %h want 0", gpio_in_s_insp); end
        read_results();
        total++; if (o_st !== 3) begin bad++; $display("FAIL reset_status: got %h want 3", o_st); end
        total++; if (o_w !== 0) begin bad++; $display("FAIL reset_w: got %h want 0", o_w); end
        total++; if (o_l !== 0) begin bad++; $display("FAIL reset_l: got %h want 0", o_l); end
        total++; if (o_hi !== 0) begin bad++; $display("FAIL reset_hi: got %h want 0", o_hi); end
        rd(R + 16'h30, o_w);
        total++; if (o_w !== 0) begin bad++; $display("FAIL unmapped_read: got %h want 0", o_w); end
    endtask

    task automatic test_basic();
        run_op(24'd3, 24'd5);
        total++; if (o_mid !== 1) begin bad++; $display("FAIL basic_busy_status: got %h want 1", o_mid); end
        total++; if (o_st !== 3) begin bad++; $display("FAIL basic_status: got %h want 3", o_st); end
        total++; if (o_w !== 15) begin bad++; $display("FAIL basic_w: got %h want f", o_w); end
        total++; if (o_l !== 4) begin bad++; $display("FAIL basic_l: got %h want 4", o_l); end
        total++; if (gpio_out !== 1) begin bad++; $display("FAIL basic_count: got %h want 1", gpio_out); end
    endtask

    task automatic test_max();
        run_op(24'hFFFFFF, 24'hFFFFFF);
        total++; if (o_st !== 2) begin bad++; $display("FAIL max_status: got %h want 2", o_st); end
        total++; if (o_w !== 32'hFE000001) begin bad++; $display("FAIL max_w: got %h want fe000001", o_w); end
        total++; if (o_l !== 8) begin bad++; $display("FAIL max_l: got %h want 8", o_l); end
        total++; if (o_hi !== e_hi) begin bad++; $display("FAIL max_hi: got %h want %h", o_hi, e_hi); end
        total++; if (gpio_out !== 2) begin bad++; $display("FAIL max_count: got %h want 2", gpio_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [23:0] a1, a2;
            a1 = 24'($urandom);
            a2 = i % 2 == 1 ? 24'($urandom) : 24'($urandom_range(255));
            run_op(a1, a2);
            total++; if (o_mid !== e_mid) begin bad++; $display("FAIL rand_busy_status[%0d]: got %h want %h", i, o_mid, e_mid); end
            total++; if (o_st !== e_st) begin bad++; $display("FAIL rand_status[%0d]: got %h want %h", i, o_st, e_st); end
            total++; if (o_w !== m_w) begin bad++; $display("FAIL rand_w[%0d]: got %h want %h", i, o_w, m_w); end
            total++; if (o_l !== m_l) begin bad++; $display("FAIL rand_l[%0d]: got %h want %h", i, o_l, m_l); end
            total++; if (o_hi !== e_hi) begin bad++; $display("FAIL rand_hi[%0d]: got %h want %h", i, o_hi, e_hi); end
            total++; if (gpio_out !== 32'(m_cnt)) begin bad++; $display("FAIL rand_count[%0d]: got %h want %h", i, gpio_out, m_cnt); end
        end
    endtask

    task automatic test_busy();
        logic [23:0] a1, a2;
        logic [31:0] prev_w;
        a1 = 24'($urandom) | 24'h800000;
        a2 = 24'($urandom) | 24'h000001;
        prev_w = m_w;
        wr(R, 32'(a1));
        wr(R + 16'h08, 32'(a2));
        wr(R + 16'h20, 0);
        wr(R, 7);
        wr(R + 16'h20, 0);
        rd(R + 16'h10, o_w);
        total++; if (o_w !== prev_w) begin bad++; $display("FAIL busy_w_hold: got %h want %h", o_w, prev_w); end
        repeat (OP_W) @(negedge clk);
        model_op(a1, a2);
        read_results();
        total++; if (o_w !== m_w) begin bad++; $display("FAIL busy_snapshot_w: got %h want %h", o_w, m_w); end
        total++; if (gpio_out !== 32'(m_cnt)) begin bad++; $display("FAIL busy_single_count: got %h want %h", gpio_out, m_cnt); end
        wr(R + 16'h20, 0);
        repeat (OP_W + 2) @(negedge clk);
        model_op(24'd7, a2);
        read_results();
        total++; if (o_w !== m_w) begin bad++; $display("FAIL busy_new_a1_w: got %h want %h", o_w, m_w); end
        total++; if (o_st !== e_st) begin bad++; $display("FAIL busy_new_a1_status: got %h want %h", o_st, e_st); end
    endtask

    task automatic test_reset_mid();
        wr(R, 32'($urandom));
        wr(R + 16'h08, 32'($urandom));
        wr(R + 16'h20, 0);
        repeat (5) @(negedge clk);
        n_reset = 0;
        #2;
        total++; if (gpio_out !== 0) begin bad++; $display("FAIL midreset_count: got %h want 0", gpio_out); end
        @(negedge clk);
        n_reset = 1;
        m_w = 0; m_l = 0; m_hi = 0; m_valid = 1; m_cnt = 0;
        read_results();
        total++; if (o_st !== 3) begin bad++; $display("FAIL midreset_status: got %h want 3", o_st); end
        total++; if (o_w !== 0) begin bad++; $display("FAIL midreset_w: got %h want 0", o_w); end
        total++; if (o_l !== 0) begin bad++; $display("FAIL midreset_l: got %h want 0", o_l); end
        run_op(24'($urandom), 24'($urandom_range(4095)));
        total++; if (o_w !== m_w) begin bad++; $display("FAIL postreset_w: got %h want %h", o_w, m_w); end
        total++; if (o_st !== e_st) begin bad++; $display("FAIL postreset_status: got %h want %h", o_st, e_st); end
        total++; if (gpio_out !== 1) begin bad++; $display("FAIL postreset_count: got %h want 1", gpio_out); end
    endtask

    task automatic test_back_to_back();
        int start_cnt;
        start_cnt = m_cnt;
        for (int i = 0; i < 16; i++) begin
            run_op(24'($urandom), 24'($urandom));
            total++; if (o_w !== m_w) begin bad++; $display("FAIL b2b_w[%0d]: got %h want %h", i, o_w, m_w); end
        end
        total++; if (gpio_out !== 32'(start_cnt)) begin bad++; $display("FAIL b2b_wrap: got %h want %h", gpio_out, start_cnt); end
    endtask

    task automatic test_gpio_latch();
        gpio_in = 32'hA5A5A5A5;
        @(negedge clk);
        gpio_latch = 1;
        @(negedge clk);
        gpio_latch = 0;
        total++; if (gpio_in_s_insp !== 32'hA5A5A5A5) begin bad++; $display("FAIL latch_value: got %h want a5a5a5a5", gpio_in_s_insp); end
        gpio_in = 32'h5A5A5A5A;
        repeat (3) @(negedge clk);
        total++; if (gpio_in_s_insp !== 32'hA5A5A5A5) begin bad++; $display("FAIL latch_hold: got %h want a5a5a5a5", gpio_in_s_insp); end
        gpio_latch = 1;
        @(negedge clk);
        gpio_latch = 0;
        total++; if (gpio_in_s_insp !== 32'h5A5A5A5A) begin bad++; $display("FAIL latch_second: got %h want 5a5a5a5a", gpio_in_s_insp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_random();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        test_gpio_latch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
